serial_arith_unit: RTL and testbench
====================================

Name: serial_arith_unit

Overview:
- Word-serial adder/subtractor driven by the 36-phase digit timing bus. It sits directly downstream of the digit pulse generator.
- Each minor cycle it combines two LSB-first serial operands (A from the accumulator tank, B from the store/multiplicand tank) into a serial result.
- The result goes back to the accumulator tank. The block also keeps a parallel copy of the result for the display/monitor logic and reports arithmetic overflow.

Parameters:
- WORD_BITS, 35, data digits per minor cycle (digits 0..WORD_BITS-1); digit WORD_BITS is the guard gap; WORD_BITS+1 must equal 36.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- digit_pulse  input  36  one-hot digit timing; bit k high for the whole clk cycle of digit k
- op  input  2  00 pass A, 01 A+B, 10 A-B, 11 clear (result 0)
- a_in  input  1  serial operand A, LSB at digit 0
- b_in  input  1  serial operand B, LSB at digit 0
- clr_ovf  input  1  clears the sticky overflow flag
- sum_out  output  1  serial result, registered
- result_word  output  35  parallel copy of the last completed result
- result_valid  output  1  one-cycle pulse when result_word updates
- ovf_pulse  output  1  one-cycle pulse, overflow in the word just completed
- ovf_flag  output  1  sticky overflow
- sync_err  output  1  sticky; digit_pulse was seen not one-hot

Behaviour:
- Reset (rst=1 at a rising edge): every output is 0, the carry is 0, the shift register is 0 and the state is WAIT.
- A reset mid-word aborts that word. There is no result_valid for it, and the block resumes at the next digit_pulse[0].
- States:
  - WAIT: idle until digit_pulse[0] is seen.
  - RUN: active during digits 0..34.
  - GAP: digit 35.
  - Transitions: WAIT→RUN on digit 0; RUN→GAP on digit 34; GAP→RUN on digit 0; any state→WAIT on sync error.
- Op latch: op is sampled only on the digit-0 cycle and held for the whole word. Changes to op at digits 1..35 have no effect until the next digit 0.
- Carry init at digit 0: 0 for pass, add and clear; 1 for subtract, where B is inverted (two's complement).
- Per digit d in 0..34:
  - add/sub: s = a ^ b' ^ c, and the carry updates to the majority of (a, b', c).
  - pass: s = a.
  - clear: s = 0.
- sum_out carries the result for digit d in the cycle after digit d (latency 1). sum_out = 0 in the cycle after digit 35.
- Shift register: s is shifted in LSB-first over digits 0..34.
- At the GAP cycle:
  - result_word is loaded with the assembled 35 bits.
  - result_valid pulses for 1 cycle.
- Overflow (add/sub only):
  - ovf = carry-in to digit 34 XOR carry-out of digit 34.
  - When set, ovf_pulse pulses during the GAP cycle and ovf_flag sets.
  - Pass and clear never raise overflow.
- ovf_flag is sticky until clr_ovf=1 or rst. If clr_ovf and a new overflow occur in the same cycle, the flag stays set (set wins).
- Sync error (digit_pulse has zero or ≥2 bits set, or a digit arrives out of order versus the internal expected index):
  - sync_err sets and the state goes to WAIT.
  - sum_out is forced 0 and the partial word is discarded.
  - sync_err clears only on rst.
- Wrap-around: 35-bit arithmetic modulo 2^35 with two's-complement sign at digit 34. The carry out of digit 34 is discarded after the overflow check.
- Back-to-back words need no idle cycle: GAP→RUN happens directly on the next digit 0.

Test Plan:
- Reset then 2 words, op=01, A=3, B=5 → serial 0b1000 on sum_out (1 cycle latency), result_word=8, result_valid at each digit 35, ovf_flag=0.
- op=10, A=0, B=1 → result_word=35'h7_FFFF_FFFF, no overflow; op=10, A=5, B=5 → 0.
- op=01, A=35'h3_FFFF_FFFF (max positive), B=1 → result_word=35'h4_0000_0000, ovf_pulse at digit 35, ovf_flag stays 1 through next clean word until clr_ovf; clr_ovf plus a coincident overflow → flag remains 1.
- op toggles 01→11 at digit 10 → current word completes as add (A=7, B=9 → 16), next word is clear → 0.
- rst asserted at digit 17 → all outputs 0 the next cycle, no result_valid for the aborted word, next full word (A=1, B=1, add) → 2.
- digit_pulse = 0x000000003 (two bits) at one cycle → sync_err=1, sum_out 0; recovery at the next digit 0 gives a correct result; sync_err stays 1 until rst.

Source files
------------

// File: rtl/serial_arith_if.sv
// Digit timing, serial operand and result/status bus of the serial arithmetic unit.
interface serial_arith_if #(
  parameter int WORD_BITS = 35
);
  logic [WORD_BITS:0]   digit_pulse;
  logic [1:0]           op;
  logic                 a_in;
  logic                 b_in;
  logic                 clr_ovf;
  logic                 sum_out;
  logic [WORD_BITS-1:0] result_word;
  logic                 result_valid;
  logic                 ovf_pulse;
  logic                 ovf_flag;
  logic                 sync_err;

  modport master (
    output digit_pulse, op, a_in, b_in, clr_ovf,
    input  sum_out, result_word, result_valid, ovf_pulse, ovf_flag, sync_err
  );

  modport slave (
    input  digit_pulse, op, a_in, b_in, clr_ovf,
    output sum_out, result_word, result_valid, ovf_pulse, ovf_flag, sync_err
  );
endinterface

// File: rtl/serial_arith_unit.sv
// Word-serial adder/subtractor locked to the 36-phase digit timing bus.
// Emits an LSB-first serial result, a parallel copy per word, and overflow/sync status.
module serial_arith_unit #(
  parameter int WORD_BITS = 35
) (
  input  logic          clk,
  input  logic          rst,
  serial_arith_if.slave bus
);

  localparam logic [5:0]           LAST_IDX = 6'(WORD_BITS - 1);
  localparam logic [1:0]           OP_PASS  = 2'b00;
  localparam logic [1:0]           OP_ADD   = 2'b01;
  localparam logic [1:0]           OP_SUB   = 2'b10;
  localparam logic [1:0]           OP_CLR   = 2'b11;
  localparam logic [WORD_BITS:0]   DP_ZERO  = {(WORD_BITS + 1){1'b0}};
  localparam logic [WORD_BITS:0]   DP_ONE   = {{WORD_BITS{1'b0}}, 1'b1};
  localparam logic [WORD_BITS-1:0] WORD_ZERO = {WORD_BITS{1'b0}};

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [WORD_BITS:0] v);
    return (v != DP_ZERO) && ((v & (v - DP_ONE)) == DP_ZERO);
  endfunction

  // Only meaningful for a one-hot input; OR-reduction of the set positions.
  function automatic logic [5:0] digit_index(input logic [WORD_BITS:0] v);
    logic [5:0] idx;
    idx = 6'd0;
    for (int k = 0; k <= WORD_BITS; k++) begin
      idx = idx | (v[k] ? 6'(k) : 6'd0);
    end
    return idx;
  endfunction

  state_t               state_r, state_nx_s;
  logic [5:0]           exp_r;
  logic [1:0]           op_r;
  logic                 carry_r;
  logic [WORD_BITS-1:0] shreg_r;
  logic                 sum_out_r;
  logic [WORD_BITS-1:0] result_word_r;
  logic                 result_valid_r;
  logic                 ovf_pulse_r;
  logic                 ovf_flag_r;
  logic                 sync_err_r;

  logic       onehot_s;
  logic [5:0] idx_s;
  logic       sync_fault_s;
  logic       first_s;
  logic       data_s;
  logic       last_s;
  logic [1:0] op_cur_s;
  logic       cin_s;
  logic       b_eff_s;
  logic       sum_s;
  logic       cout_s;
  logic       ovf_s;

  // Qualify the current digit against the one-hot rule and the expected sequence.
  always_comb begin
    onehot_s     = is_onehot(bus.digit_pulse);
    idx_s        = digit_index(bus.digit_pulse);
    sync_fault_s = 1'b0;
    case (state_r)
      ST_WAIT:        sync_fault_s = !onehot_s;
      ST_RUN, ST_GAP: sync_fault_s = !onehot_s || (idx_s != exp_r);
      default:        sync_fault_s = 1'b1;
    endcase
    first_s = !sync_fault_s && bus.digit_pulse[0];
    data_s  = first_s || (!sync_fault_s && (state_r == ST_RUN));
    last_s  = data_s && (idx_s == LAST_IDX);
  end

  // One bit slice of the adder; op and carry seed come from the bus on digit 0.
  always_comb begin
    op_cur_s = op_r;
    cin_s    = carry_r;
    if (first_s) begin
      op_cur_s = bus.op;
      cin_s    = (bus.op == OP_SUB);
    end else begin
      op_cur_s = op_r;
      cin_s    = carry_r;
    end
    b_eff_s = bus.b_in ^ (op_cur_s == OP_SUB);
    sum_s   = 1'b0;
    cout_s  = cin_s;
    ovf_s   = 1'b0;
    case (op_cur_s)
      OP_ADD, OP_SUB: begin
        sum_s  = bus.a_in ^ b_eff_s ^ cin_s;
        cout_s = (bus.a_in & b_eff_s) | (bus.a_in & cin_s) | (b_eff_s & cin_s);
        ovf_s  = last_s && (cin_s ^ cout_s);
      end
      OP_PASS: sum_s = bus.a_in;
      OP_CLR:  sum_s = 1'b0;
      default: sum_s = 1'b0;
    endcase
  end

  // Next-state logic; GAP covers digit 35 and waits there for the next digit 0.
  always_comb begin
    state_nx_s = state_r;
    if (sync_fault_s) begin
      state_nx_s = ST_WAIT;
    end else begin
      case (state_r)
        ST_WAIT: state_nx_s = first_s ? ST_RUN : ST_WAIT;
        ST_RUN:  state_nx_s = last_s ? ST_GAP : ST_RUN;
        ST_GAP:  state_nx_s = first_s ? ST_RUN : ST_GAP;
        default: state_nx_s = ST_WAIT;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_WAIT;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath, result capture and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_r          <= 6'd0;
      op_r           <= OP_PASS;
      carry_r        <= 1'b0;
      shreg_r        <= WORD_ZERO;
      sum_out_r      <= 1'b0;
      result_word_r  <= WORD_ZERO;
      result_valid_r <= 1'b0;
      ovf_pulse_r    <= 1'b0;
      ovf_flag_r     <= 1'b0;
      sync_err_r     <= 1'b0;
    end else begin
      result_valid_r <= 1'b0;
      ovf_pulse_r    <= ovf_s;
      // A new overflow wins over a coincident clear.
      ovf_flag_r     <= (ovf_flag_r & ~bus.clr_ovf) | ovf_s;
      if (sync_fault_s) begin
        sync_err_r <= 1'b1;
        sum_out_r  <= 1'b0;
        shreg_r    <= WORD_ZERO;
        carry_r    <= 1'b0;
        exp_r      <= 6'd0;
      end else if (data_s) begin
        sum_out_r <= sum_s;
        shreg_r   <= {sum_s, shreg_r[WORD_BITS-1:1]};
        carry_r   <= cout_s;
        op_r      <= op_cur_s;
        exp_r     <= idx_s + 6'd1;
        if (last_s) begin
          result_word_r  <= {sum_s, shreg_r[WORD_BITS-1:1]};
          result_valid_r <= 1'b1;
        end else begin
          result_word_r  <= result_word_r;
        end
      end else begin
        sum_out_r <= 1'b0;
        exp_r     <= 6'd0;
      end
    end
  end

  assign bus.sum_out      = sum_out_r;
  assign bus.result_word  = result_word_r;
  assign bus.result_valid = result_valid_r;
  assign bus.ovf_pulse    = ovf_pulse_r;
  assign bus.ovf_flag     = ovf_flag_r;
  assign bus.sync_err     = sync_err_r;

endmodule

// File: tb/tb_serial_arith_unit.sv
// Bench for serial_arith_unit: drives whole digit-bus words and compares every cycle
// against a word-level arithmetic model, with expected results queued per word.
module tb_serial_arith_unit;
  localparam int NONE = 99;
  localparam logic [35:0] DP_GAP = 36'h8_0000_0000;

  typedef struct packed {
    logic [34:0] word;
    logic        ovf;
  } res_t;

  logic clk;
  logic rst;
  serial_arith_if bus ();
  serial_arith_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int          checks   = 0;
  int          failures = 0;
  res_t        res_q[$];
  logic [34:0] rw_m;
  logic        flag_m;
  logic        sync_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge pass, then compare all outputs.
  task automatic tick(input logic [35:0] dp, input logic [1:0] opv, input logic av,
                      input logic bv, input logic clrv, input logic rstv,
                      input logic esum, input logic evalid);
    res_t it;
    logic ovf_now;
    it = '0;
    ovf_now = 1'b0;
    bus.digit_pulse = dp;
    bus.op          = opv;
    bus.a_in        = av;
    bus.b_in        = bv;
    bus.clr_ovf     = clrv;
    rst             = rstv;
    @(posedge clk);
    #1;
    if (rstv) begin
      rw_m   = '0;
      flag_m = 1'b0;
      sync_m = 1'b0;
    end else begin
      if (evalid) begin
        check_eq("sb_depth", 64'(res_q.size() != 0), 64'd1);
        if (res_q.size() != 0) begin
          it      = res_q.pop_front();
          rw_m    = it.word;
          ovf_now = it.ovf;
        end
      end
      flag_m = (flag_m & ~clrv) | ovf_now;
      if ($countones(dp) != 1) sync_m = 1'b1;
    end
    check_eq("sum_out",      64'(bus.sum_out),      64'(rstv ? 1'b0 : esum));
    check_eq("result_valid", 64'(bus.result_valid), 64'(rstv ? 1'b0 : evalid));
    check_eq("result_word",  64'(bus.result_word),  64'(rw_m));
    check_eq("ovf_pulse",    64'(bus.ovf_pulse),    64'(ovf_now));
    check_eq("ovf_flag",     64'(bus.ovf_flag),     64'(flag_m));
    check_eq("sync_err",     64'(bus.sync_err),     64'(sync_m));
  endtask

  // A full 36-digit word; op may switch at op_switch, and the word may be
  // disturbed by clr_ovf, a reset or a corrupted digit at the given digits.
  task automatic run_word(input logic [1:0] op0, input logic [1:0] op_late, input int op_switch,
                          input logic [34:0] a, input logic [34:0] b,
                          input int clr_at, input int abort_at, input int err_at);
    logic [34:0] r;
    logic        ovf;
    logic        live;
    logic [35:0] dp;
    logic [1:0]  opv;
    logic        av;
    logic        bv;
    logic        esum;
    res_t        it;
    ovf = 1'b0;
    case (op0)
      2'b00:   r = a;
      2'b01: begin
        r   = a + b;
        ovf = (a[34] == b[34]) && (r[34] != a[34]);
      end
      2'b10: begin
        r   = a - b;
        ovf = (a[34] != b[34]) && (r[34] != a[34]);
      end
      default: r = '0;
    endcase
    if (abort_at == NONE && err_at == NONE) begin
      it.word = r;
      it.ovf  = ovf;
      res_q.push_back(it);
    end
    live = 1'b1;
    for (int d = 0; d < 36; d++) begin
      dp = 36'd1 << d;
      if (d == err_at) dp = 36'h0_0000_0003;
      if (d == err_at || d == abort_at) live = 1'b0;
      opv  = (d >= op_switch) ? op_late : op0;
      esum = 1'b0;
      if (d < 35) begin
        av = a[d];
        bv = b[d];
        if (live) esum = r[d];
      end else begin
        av = 1'($urandom_range(0, 1));
        bv = 1'($urandom_range(0, 1));
      end
      tick(dp, opv, av, bv, (d == clr_at), (d == abort_at), esum, live && (d == 34));
    end
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    rst             = 1'b1;
    bus.digit_pulse = DP_GAP;
    bus.op          = 2'b00;
    bus.a_in        = 1'b0;
    bus.b_in        = 1'b0;
    bus.clr_ovf     = 1'b0;
    rw_m            = '0;
    flag_m          = 1'b0;
    sync_m          = 1'b0;

    for (int i = 0; i < 3; i++) tick(DP_GAP, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    run_word(2'b01, 2'b01, NONE, 35'd3, 35'd5, NONE, NONE, NONE);
    run_word(2'b01, 2'b01, NONE, 35'd3, 35'd5, NONE, NONE, NONE);
    run_word(2'b10, 2'b10, NONE, 35'd0, 35'd1, NONE, NONE, NONE);
    run_word(2'b10, 2'b10, NONE, 35'd5, 35'd5, NONE, NONE, NONE);

    // Overflow, sticky flag, clear, and clear coinciding with a new overflow.
    run_word(2'b01, 2'b01, NONE, 35'h3_FFFF_FFFF, 35'd1, NONE, NONE, NONE);
    run_word(2'b01, 2'b01, NONE, 35'd3, 35'd5, NONE, NONE, NONE);
    run_word(2'b01, 2'b01, NONE, 35'd3, 35'd5, 5, NONE, NONE);
    run_word(2'b01, 2'b01, NONE, 35'h3_FFFF_FFFF, 35'd1, 34, NONE, NONE);
    run_word(2'b10, 2'b10, NONE, 35'h4_0000_0000, 35'd1, NONE, NONE, NONE);
    run_word(2'b00, 2'b00, NONE, 35'h7_FFFF_FFFF, 35'h7_FFFF_FFFF, 0, NONE, NONE);

    // Op change mid-word only affects the next word.
    run_word(2'b01, 2'b11, 10, 35'd7, 35'd9, NONE, NONE, NONE);
    run_word(2'b11, 2'b11, NONE, 35'd123, 35'd45, NONE, NONE, NONE);

    for (int i = 0; i < 6; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      run_word(2'(i % 3), 2'((i + 1) % 4), 20, ra[34:0], rb[34:0], NONE, NONE, NONE);
    end

    // Reset mid-word, then a clean word.
    run_word(2'b01, 2'b01, NONE, 35'h1234, 35'h777, NONE, 17, NONE);
    run_word(2'b01, 2'b01, NONE, 35'd1, 35'd1, NONE, NONE, NONE);

    // Corrupted digit, recovery on the next digit 0, sticky sync_err until reset.
    run_word(2'b01, 2'b01, NONE, 35'h100, 35'h23, NONE, NONE, 12);
    run_word(2'b01, 2'b01, NONE, 35'h100, 35'h23, NONE, NONE, NONE);
    run_word(2'b10, 2'b10, NONE, 35'd9, 35'd20, NONE, NONE, NONE);
    for (int i = 0; i < 2; i++) tick(DP_GAP, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_word(2'b01, 2'b01, NONE, 35'd3, 35'd5, NONE, NONE, NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
